relu_grad_stream: RTL and testbench
===================================

Name: relu_grad_stream

Overview:
- Backward-direction companion to the forward ReLU: gates a stream of incoming gradients by the sign of the matching forward pre-activation values.
- Forward pre-activations are written in first and stored as 1-bit masks (x > 0) in an internal FIFO.
- Gradients are then read against that FIFO in order; each gradient passes unchanged where mask=1 and is zeroed where mask=0.
- Sits between the near-memory activation buffer and the backward datapath.

Parameters:
- DATA_WIDTH, 8, width of pre-activation and gradient words (two's complement).
- DEPTH, 64, mask FIFO entries; must be a power of 2.
- ADDR_W, 6, pointer width; log2(DEPTH).
- LEAK_SHIFT, 3, arithmetic right-shift for the leaky slope; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the FIFO and output register.
- act_valid  in  1  forward pre-activation is present.
- act_ready  out  1  mask FIFO can accept a word.
- act_in  in  DATA_WIDTH  signed forward pre-activation.
- grad_in_valid  in  1  upstream gradient is present.
- grad_in_ready  out  1  gradient is accepted this cycle.
- grad_in  in  DATA_WIDTH  signed upstream gradient.
- grad_out_valid  out  1  gated gradient is available.
- grad_out_ready  in  1  downstream accepts grad_out.
- grad_out  out  DATA_WIDTH  signed gated gradient.
- mask_count  out  ADDR_W+1  number of stored mask entries.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, mask_count=0.
  - grad_out_valid=0, grad_out=0.
  - act_ready=1, grad_in_ready=0.
  - Mask storage contents are don't-care.
- Mask write:
  - act_ready = (mask_count != DEPTH).
  - Push occurs when act_valid && act_ready.
  - Stored bit = (act_in > 0) under signed compare; 0 and negative values store 0.
  - wr_ptr increments and wraps modulo DEPTH.
- Gradient read:
  - grad_in_ready = (mask_count != 0) && (!grad_out_valid || grad_out_ready); purely combinational from state and grad_out_ready.
  - Pop occurs when grad_in_valid && grad_in_ready.
  - rd_ptr increments and wraps modulo DEPTH.
- Output register:
  - On a pop, grad_out <= mask ? grad_in : 0 and grad_out_valid <= 1.
  - On a cycle where grad_out_ready && !pop, grad_out_valid <= 0 and grad_out holds its value.
  - grad_out is stable while grad_out_valid && !grad_out_ready.
  - Latency: 1 cycle from grad_in handshake to grad_out_valid.
  - Throughput: 1 gradient per cycle when downstream ready is held high.
- Simultaneous push and pop in one cycle:
  - Both complete and mask_count is unchanged.
  - A push into an empty FIFO is not visible to grad_in_ready until the next cycle (no bypass).
  - When full, act_ready=0 even if a pop occurs the same cycle (no pass-through).
- Flush (synchronous, priority over every handshake in that cycle):
  - Pointers and count cleared, grad_out_valid=0.
  - Any push or pop in that cycle is discarded.
  - act_ready=1 and grad_in_ready=0 on the following cycle.
- Reset mid-stream: all in-flight data is lost; outputs return to reset values immediately (asynchronously).
- Ordering: masks are consumed strictly FIFO; the i-th gradient is gated by the i-th pre-activation.
- Count invariant: mask_count = wr_ptr - rd_ptr, tracked with an explicit counter so that full and empty are distinguishable.

Optional Feature:
- Macro: RELU_GRAD_LEAKY_EN.
- Defined: mask=0 entries output grad_in >>> LEAK_SHIFT (arithmetic, sign-preserving, truncation toward -inf) instead of 0, giving leaky-ReLU backward.
- Undefined: mask=0 entries output exactly 0, and LEAK_SHIFT is unused.

Test Plan:
- Reset then idle -> act_ready=1, grad_in_ready=0, grad_out_valid=0, mask_count=0.
- Push act 5, -3, 0, 127 then grads 10, 10, -7, -128 with grad_out_ready=1 -> grad_out 10, 0, 0, -128, each 1 cycle after its handshake. With RELU_GRAD_LEAKY_EN and LEAK_SHIFT=3, the second and third outputs become 1 and -1.
- Push 64 acts -> act_ready=0 at mask_count=64. A 65th act is held off; pop one -> act_ready=1 the next cycle. Fill and drain twice more -> pointer wrap preserves order.
- grad_out_ready=0 with output valid -> grad_out holds, grad_in_ready=0, no pop. Release -> the next gradient is accepted that cycle.
- Push and pop in the same cycle at mask_count=3 -> mask_count stays 3. Push into an empty FIFO -> grad_in_ready rises one cycle later.
- Assert flush with mask_count=10 and output valid -> next cycle mask_count=0 and grad_out_valid=0. Pulse rst mid-stream -> outputs return to reset values immediately.

Source files
------------

// File: rtl/relu_grad_stream.sv
// ----------------------------------------------------------------------------
// relu_grad_stream
//
// Backward pass of a ReLU over a stream. The forward pre-activations are
// written first and kept only as 1-bit masks (x > 0) in a small FIFO. Each
// incoming gradient is then gated by the oldest stored mask:
//   - mask = 1: the gradient passes through unchanged.
//   - mask = 0: the output is zero.
//
// Optional feature, selected by the macro RELU_GRAD_LEAKY_EN:
//   When the macro is defined, mask = 0 entries output
//   grad_in >>> LEAK_SHIFT (arithmetic shift, rounds toward -inf).
//   This gives the backward pass of a leaky ReLU.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   flush           synchronous clear of the FIFO and the output register
//   act_valid/ready forward pre-activation write (act_in, signed)
//   grad_in_*       upstream gradient handshake (grad_in, signed)
//   grad_out_*      gated gradient, registered, 1 cycle after the handshake
//   mask_count      number of masks currently stored (0..DEPTH)
// ----------------------------------------------------------------------------
module relu_grad_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [DATA_WIDTH-1:0] act_in,
    input  logic                  grad_in_valid,
    output logic                  grad_in_ready,
    input  logic [DATA_WIDTH-1:0] grad_in,
    output logic                  grad_out_valid,
    input  logic                  grad_out_ready,
    output logic [DATA_WIDTH-1:0] grad_out,
    output logic [ADDR_W:0]       mask_count
);

`ifdef RELU_GRAD_LEAKY_EN
    localparam bit LEAKY_EN = 1'b1;
`else
    localparam bit LEAKY_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0]     wr_ptr_reg;
    logic [ADDR_W-1:0]     rd_ptr_reg;
    logic [ADDR_W:0]       count_reg;
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] out_reg;

    // Mask storage. It is not reset because its contents are never
    // observed before being written.
    logic                  mask_mem [DEPTH];

    logic                  push;
    logic                  pop;
    logic                  rd_mask;
    logic [DATA_WIDTH-1:0] leak_val;
    logic [DATA_WIDTH-1:0] gated_next;

    // Readiness is derived only from registered state; a push into an empty
    // FIFO becomes poppable on the following cycle. There is no bypass.
    assign act_ready     = (count_reg != FULL_COUNT);
    assign grad_in_ready = (count_reg != '0) && (!valid_reg || grad_out_ready);

    // A flush discards any handshake in the same cycle.
    assign push = act_valid && act_ready && !flush;
    assign pop  = grad_in_valid && grad_in_ready && !flush;

    assign rd_mask  = mask_mem[rd_ptr_reg];
    assign leak_val = DATA_WIDTH'($signed(grad_in) >>> LEAK_SHIFT);

    always_comb begin
        gated_next = '0;
        if (rd_mask) begin
            gated_next = grad_in;
        end else if (LEAKY_EN) begin
            gated_next = leak_val;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr_reg] <= ($signed(act_in) > 0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            out_reg    <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            out_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // An explicit counter keeps full (DEPTH) distinct from empty (0).
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // The output register loads on a pop. It is released when the
            // consumer takes the value. The data holds while the consumer stalls.
            if (pop) begin
                out_reg   <= gated_next;
                valid_reg <= 1'b1;
            end else if (grad_out_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign grad_out_valid = valid_reg;
    assign grad_out       = out_reg;
    assign mask_count     = count_reg;

endmodule

// File: tb/tb_relu_grad_stream.sv
module tb_relu_grad_stream;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LS    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          act_valid = 1'b0;
    logic          act_ready;
    logic [DW-1:0] act_in = '0;
    logic          grad_in_valid = 1'b0;
    logic          grad_in_ready;
    logic [DW-1:0] grad_in = '0;
    logic          grad_out_valid;
    logic          grad_out_ready = 1'b0;
    logic [DW-1:0] grad_out;
    logic [AW:0]   mask_count;

    relu_grad_stream #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LEAK_SHIFT(LS)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
        .grad_in_valid(grad_in_valid), .grad_in_ready(grad_in_ready), .grad_in(grad_in),
        .grad_out_valid(grad_out_valid), .grad_out_ready(grad_out_ready), .grad_out(grad_out),
        .mask_count(mask_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit                   mq[$];
    int                   m_count = 0;
    bit                   m_valid = 1'b0;
    logic signed [DW-1:0] m_out = '0;

    typedef struct {
        logic signed [DW-1:0] act;
        logic signed [DW-1:0] grad;
        logic signed [DW-1:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [DW-1:0] gate(input bit m, input logic signed [DW-1:0] g);
        if (m) return g;
`ifdef RELU_GRAD_LEAKY_EN
        return g >>> LS;
`else
        return '0;
`endif
    endfunction

    // One clock cycle with the given inputs. The task checks ready signals
    // before the edge and registered outputs 1 time unit after it.
    task automatic cyc(input bit av, input logic signed [DW-1:0] a,
                       input bit gv, input logic signed [DW-1:0] g,
                       input bit gr, input bit fl);
        bit exp_ar, exp_gr, push, pop, m;
        act_valid = av; act_in = a; grad_in_valid = gv; grad_in = g;
        grad_out_ready = gr; flush = fl;
        #1;
        exp_ar = (m_count != DEPTH);
        exp_gr = (m_count != 0) && (!m_valid || gr);
        chk("act_ready", {31'b0, act_ready}, {31'b0, exp_ar});
        chk("grad_in_ready", {31'b0, grad_in_ready}, {31'b0, exp_gr});
        push = av && exp_ar;
        pop  = gv && exp_gr;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete(); m_valid = 1'b0; m_out = '0;
        end else begin
            if (pop) begin
                m = mq.pop_front();
                m_out = gate(m, g);
                m_valid = 1'b1;
            end else if (gr) begin
                m_valid = 1'b0;
            end
            if (push) mq.push_back(a > 0);
        end
        m_count = mq.size();
        chk("mask_count", {25'b0, mask_count}, m_count);
        chk("grad_out_valid", {31'b0, grad_out_valid}, {31'b0, m_valid});
        chk("grad_out", $signed(grad_out), m_out);
        act_valid = 1'b0; grad_in_valid = 1'b0; flush = 1'b0;
        $display("[TB] cyc av=%0b a=%0d gv=%0b g=%0d gr=%0b fl=%0b -> cnt=%0d v=%0b out=%0d",
                 av, a, gv, g, gr, fl, mask_count, grad_out_valid, $signed(grad_out));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_act_ready"}, {31'b0, act_ready}, 1);
        chk({tag, "_grad_in_ready"}, {31'b0, grad_in_ready}, 0);
        chk({tag, "_grad_out_valid"}, {31'b0, grad_out_valid}, 0);
        chk({tag, "_mask_count"}, {25'b0, mask_count}, 0);
        chk({tag, "_grad_out"}, $signed(grad_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [DW-1:0] av;
        // act, grad, expected output (hand computed)
        tbl[0] = '{ 8'sd5,    8'sd10,   8'sd10 };
`ifdef RELU_GRAD_LEAKY_EN
        tbl[1] = '{ -8'sd3,   8'sd10,   8'sd1 };
        tbl[2] = '{ 8'sd0,    -8'sd7,   -8'sd1 };
        tbl[4] = '{ -8'sd128, 8'sd127,  8'sd15 };
        tbl[6] = '{ -8'sd1,   -8'sd128, -8'sd16 };
`else
        tbl[1] = '{ -8'sd3,   8'sd10,   8'sd0 };
        tbl[2] = '{ 8'sd0,    -8'sd7,   8'sd0 };
        tbl[4] = '{ -8'sd128, 8'sd127,  8'sd0 };
        tbl[6] = '{ -8'sd1,   -8'sd128, 8'sd0 };
`endif
        tbl[3] = '{ 8'sd127,  -8'sd128, -8'sd128 };
        tbl[5] = '{ 8'sd1,    -8'sd1,   -8'sd1 };
        tbl[7] = '{ 8'sd64,   8'sd0,    8'sd0 };

        // Reset, then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        check_idle("idle");

        // Table-driven: push all pre-activations, then stream gradients back to back
        for (int i = 0; i < 8; i++) cyc(1, tbl[i].act, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, tbl[i].grad, 1, 0);
            chk("tbl_out", $signed(grad_out), tbl[i].exp);
        end
        cyc(0, 0, 0, 0, 1, 0);

        // Fill to full, hold off a 65th write, free one slot, then fill and drain repeatedly
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                av = ((i + r) % 3 == 0) ? DW'(-(i + 1)) : DW'(i + 1);
                cyc(1, av, 0, 0, 1, 0);
            end
            chk("full_count", {25'b0, mask_count}, DEPTH);
            if (r == 0) begin
                cyc(1, 8'sd9, 0, 0, 1, 0);
                cyc(1, 8'sd9, 1, 8'sd33, 1, 0);
                cyc(1, 8'sd9, 0, 0, 1, 0);
            end
            for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, DW'(i + 2 + r), 1, 0);
            cyc(0, 0, 0, 0, 1, 0);
        end

        // Back-pressure: output holds, no pop while the consumer stalls
        cyc(1, 8'sd11, 0, 0, 1, 0);
        cyc(1, 8'sd22, 0, 0, 1, 0);
        cyc(1, 8'sd33, 0, 0, 1, 0);
        cyc(0, 0, 1, 8'sd5, 1, 0);
        cyc(0, 0, 1, 8'sd6, 0, 0);
        cyc(0, 0, 1, 8'sd6, 0, 0);
        chk("stall_hold", $signed(grad_out), 5);
        cyc(0, 0, 1, 8'sd6, 1, 0);
        chk("release_out", $signed(grad_out), 6);

        // Push and pop together at mask_count = 3
        cyc(1, -8'sd2, 0, 0, 1, 0);
        cyc(1, 8'sd3, 0, 0, 1, 0);
        cyc(1, -8'sd4, 1, 8'sd7, 1, 0);
        chk("pushpop_count", {25'b0, mask_count}, 3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, DW'(-20 - i), 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Push into an empty FIFO: pop becomes possible only a cycle later
        cyc(1, 8'sd20, 1, 8'sd8, 1, 0);
        cyc(0, 0, 1, 8'sd8, 1, 0);
        chk("late_pop_out", $signed(grad_out), 8);
        cyc(0, 0, 0, 0, 1, 0);

        // Flush with mask_count = 10 and valid output, while handshakes are offered
        for (int i = 0; i < 11; i++) cyc(1, DW'(i - 5), 0, 0, 1, 0);
        cyc(0, 0, 1, 8'sd50, 1, 0);
        chk("preflush_count", {25'b0, mask_count}, 10);
        cyc(1, 8'sd1, 1, 8'sd51, 0, 1);
        check_idle("flush");
        cyc(0, 0, 0, 0, 1, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1, 8'sd7, 0, 0, 1, 0);
        cyc(0, 0, 1, 8'sd44, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        mq.delete(); m_count = 0; m_valid = 1'b0; m_out = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 8'sd12, 0, 0, 1, 0);
        cyc(0, 0, 1, -8'sd9, 1, 0);
        chk("post_rst_out", $signed(grad_out), -9);
        cyc(0, 0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
